// File: rtl/pads_pwr_seq.sv
// Pad-ring and core power-up sequencer.
// Waits for a synchronized IO supply good, then enables pad inputs, pad
// outputs, holds and releases core reset, and finally enables fetch.
// Supply loss after the pads are driven latches a FAULT that software clears.
module pads_pwr_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int IO_SETTLE_CYCLES = 16,
  parameter int CORE_RST_CYCLES  = 32,
  parameter int CNT_W            = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwr_good_i,
  input  logic       sw_rst_req_i,
  input  logic       fetch_hold_i,
  input  logic       fault_clr_i,
  output logic       pad_ie_o,
  output logic       pad_oe_o,
  output logic       core_rst_no,
  output logic       fetch_en_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_IO_SETTLE = 3'd1,
    S_CORE_RST  = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(CORE_RST_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    pg_s;
  logic                    ie_q, ie_d;
  logic                    oe_q, oe_d;
  logic                    crst_n_q, crst_n_d;
  logic                    fetch_q, fetch_d;
  logic                    fault_q, fault_d;

  assign pg_s = sync_q[SYNC_STAGES-1];

  // Shift the raw supply status through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwr_good_i};
  end

  // Next state, counter and registered output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (pg_s) begin
          state_d = S_IO_SETTLE;
          cnt_d   = IO_LOAD;
        end
      end
      S_IO_SETTLE: begin
        // Supply never fully came up: quietly start over, no fault.
        if (!pg_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_CORE_RST;
          cnt_d   = RST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CORE_RST: begin
        if (!pg_s) begin
          state_d = S_FAULT;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        // Supply loss outranks a concurrent software reset request.
        if (!pg_s) begin
          state_d = S_FAULT;
        end else if (sw_rst_req_i) begin
          state_d = S_CORE_RST;
          cnt_d   = RST_LOAD;
        end
      end
      S_FAULT: begin
        if (fault_clr_i && pg_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ie_d     = (state_d == S_IO_SETTLE) || (state_d == S_CORE_RST) || (state_d == S_RUN);
    oe_d     = (state_d == S_CORE_RST) || (state_d == S_RUN);
    crst_n_d = (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
    // Fetch lags RUN entry by one edge and drops on the same edge RUN is left.
    fetch_d  = (state_q == S_RUN) && (state_d == S_RUN) && !fetch_hold_i;
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      ie_q     <= 1'b0;
      oe_q     <= 1'b0;
      crst_n_q <= 1'b0;
      fetch_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      ie_q     <= ie_d;
      oe_q     <= oe_d;
      crst_n_q <= crst_n_d;
      fetch_q  <= fetch_d;
      fault_q  <= fault_d;
    end
  end

  assign pad_ie_o    = ie_q;
  assign pad_oe_o    = oe_q;
  assign core_rst_no = crst_n_q;
  assign fetch_en_o  = fetch_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pads_pwr_seq.sv
// Bench for pads_pwr_seq: directed scenarios plus random stimulus, all
// compared cycle by cycle against a phase/time-left reference model.
module tb_pads_pwr_seq;
  localparam int SYNC = 2;
  localparam int IO_N = 16;
  localparam int CR_N = 32;

  logic clk = 1'b0;
  logic rst_n, pwr_good, sw_rst, fetch_hold, fault_clr;
  logic pad_ie, pad_oe, core_rst_n, fetch_en, fault;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  // reference model: phase 0 idle,1 settle,2 core reset,3 run,4 fault
  int m_ph;
  int m_left;
  bit m_fetch;
  bit m_sync[SYNC];

  pads_pwr_seq #(.SYNC_STAGES(SYNC), .IO_SETTLE_CYCLES(IO_N),
                 .CORE_RST_CYCLES(CR_N), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pwr_good_i(pwr_good), .sw_rst_req_i(sw_rst),
    .fetch_hold_i(fetch_hold), .fault_clr_i(fault_clr), .pad_ie_o(pad_ie),
    .pad_oe_o(pad_oe), .core_rst_no(core_rst_n), .fetch_en_o(fetch_en),
    .fault_o(fault), .state_o(state));

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {state, pad_ie, pad_oe, core_rst_n, fetch_en, fault};
  endfunction

  function automatic logic [7:0] mdl_vec();
    logic [2:0] ph = 3'(m_ph);
    return {ph, (m_ph >= 1 && m_ph <= 3), (m_ph == 2 || m_ph == 3),
            (m_ph == 3), m_fetch, (m_ph == 4)};
  endfunction

  task automatic m_reset();
    m_ph = 0; m_left = 0; m_fetch = 0;
    for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
  endtask

  task automatic m_step();
    bit pg = m_sync[SYNC-1];
    int prev = m_ph;
    for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = pwr_good;
    case (m_ph)
      0: if (pg) begin m_ph = 1; m_left = IO_N; end
      1: if (!pg) m_ph = 0;
         else begin m_left--; if (m_left == 0) begin m_ph = 2; m_left = CR_N; end end
      2: if (!pg) m_ph = 4;
         else begin m_left--; if (m_left == 0) m_ph = 3; end
      3: if (!pg) m_ph = 4;
         else if (sw_rst) begin m_ph = 2; m_left = CR_N; end
      default: if (fault_clr && pg) m_ph = 0;
    endcase
    m_fetch = (prev == 3) && (m_ph == 3) && !fetch_hold;
  endtask

  // one clock: model follows the edge, outputs are then sampled at negedge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; pwr_good = 0; sw_rst = 0; fetch_hold = 0; fault_clr = 0;
    m_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (dut_vec() !== 8'h00) begin
      miscompares++; $display("FAIL reset: got %h want %h", dut_vec(), 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL reset_idle: got %h want %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_power_up();
    int t_set = -1, t_cr = -1, t_run = -1, t_fe = -1;
    do_reset();
    pwr_good = 1;
    for (int k = 0; k < 60; k++) begin
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL power_up cyc %0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      if (state == 3'd1 && t_set < 0) t_set = k;
      if (state == 3'd2 && t_cr < 0) t_cr = k;
      if (state == 3'd3 && t_run < 0) t_run = k;
      if (fetch_en && t_fe < 0) t_fe = k;
    end
    // k counts from 0 at the first edge after raising pwr_good
    vectors++;
    if ({t_set, t_cr, t_run, t_fe} !== {32'd2, 32'd18, 32'd50, 32'd51}) begin
      miscompares++;
      $display("FAIL power_up_timing: got %0d/%0d/%0d/%0d want 2/18/50/51", t_set, t_cr, t_run, t_fe);
    end
  endtask

  task automatic test_brownout();
    int t_run = -1;
    do_reset();
    pwr_good = 1;
    for (int k = 0; k < 7; k++) tick();   // 5 cycles into IO_SETTLE
    pwr_good = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL brownout: got %h want %h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (dut_vec() !== 8'h00) begin
      miscompares++; $display("FAIL brownout_idle: got %h want 00", dut_vec());
    end
    pwr_good = 1;
    for (int k = 0; k < 55; k++) begin
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL brownout_restart: got %h want %h", dut_vec(), mdl_vec());
      end
      if (state == 3'd3 && t_run < 0) t_run = k;
    end
    vectors++;
    if (t_run !== 50) begin
      miscompares++; $display("FAIL brownout_rerun: got %0d want 50", t_run);
    end
  endtask

  task automatic test_supply_loss();
    pwr_good = 0;
    for (int k = 0; k < SYNC + 1; k++) tick();
    vectors++;
    if (dut_vec() !== {3'd4, 5'b00001}) begin
      miscompares++; $display("FAIL loss_fault: got %h want %h", dut_vec(), {3'd4, 5'b00001});
    end
    fault_clr = 1; tick(); fault_clr = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); vectors++;
      if (state !== 3'd4 || dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL clr_no_pg: got %h want %h", dut_vec(), mdl_vec());
      end
    end
    pwr_good = 1;
    for (int k = 0; k < SYNC + 1; k++) tick();
    fault_clr = 1; tick(); fault_clr = 0;
    vectors++;
    if (dut_vec() !== 8'h00) begin
      miscompares++; $display("FAIL clr_exit: got %h want 00", dut_vec());
    end
    for (int k = 0; k < 55; k++) begin
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL post_clear: got %h want %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_soft_reset();
    int n = 0;
    sw_rst = 1; tick(); sw_rst = 0;
    vectors++;
    if (dut_vec() !== {3'd2, 5'b11000}) begin
      miscompares++; $display("FAIL soft_enter: got %h want %h", dut_vec(), {3'd2, 5'b11000});
    end
    while (state == 3'd2 && n < 100) begin
      n++;
      vectors++;
      if (pad_oe !== 1'b1 || dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL soft_hold: got %h want %h", dut_vec(), mdl_vec());
      end
      tick();
    end
    vectors++;
    if (n !== CR_N || state !== 3'd3) begin
      miscompares++; $display("FAIL soft_len: got %0d st %0d want %0d st 3", n, state, CR_N);
    end
    do_reset();
    pwr_good = 1;
    for (int k = 0; k < 4; k++) tick();
    sw_rst = 1; tick(); sw_rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); vectors++;
      if (state !== 3'd1 || dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL soft_ignored: got %h want %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pwr_good = 1;
    for (int k = 0; k < 55; k++) tick();
    pwr_good = 0;
    for (int k = 0; k < SYNC; k++) tick();
    sw_rst = 1; tick(); sw_rst = 0;
    vectors++;
    if (state !== 3'd4 || dut_vec() !== mdl_vec()) begin
      miscompares++; $display("FAIL simultaneous: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_fetch_hold();
    do_reset();
    fetch_hold = 1; pwr_good = 1;
    for (int k = 0; k < 55; k++) tick();
    vectors++;
    if ({core_rst_n, fetch_en} !== 2'b10) begin
      miscompares++; $display("FAIL fetch_held: got %b want 10", {core_rst_n, fetch_en});
    end
    fetch_hold = 0; tick();
    vectors++;
    if (fetch_en !== 1'b1 || dut_vec() !== mdl_vec()) begin
      miscompares++; $display("FAIL fetch_release: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pwr_good = 1;
    for (int k = 0; k < 25; k++) tick();
    vectors++;
    if (state !== 3'd2) begin
      miscompares++; $display("FAIL async_pre: got %0d want 2", state);
    end
    #2 rst_n = 0;
    #1;
    m_reset();
    vectors++;
    if (dut_vec() !== 8'h00) begin
      miscompares++; $display("FAIL async_reset: got %h want 00", dut_vec());
    end
    tick(); rst_n = 1;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(63) == 0) pwr_good = ~pwr_good;
      if ($urandom_range(7) == 0) fetch_hold = ~fetch_hold;
      sw_rst    = ($urandom_range(15) == 0);
      fault_clr = ($urandom_range(15) == 0);
      rst_n     = ($urandom_range(499) != 0);
      tick(); vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    rst_n = 0; pwr_good = 0; sw_rst = 0; fetch_hold = 0; fault_clr = 0;
    m_reset();
    @(negedge clk);
    test_reset();
    test_power_up();
    test_brownout();
    test_supply_loss();
    test_soft_reset();
    test_simultaneous();
    test_fetch_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
